ifid_stage_reg: RTL and testbench

Parametrised IF→ID pipeline stage register that generalises the existing bubble-controlled latch. It adds a valid/ready handshake, a 2-entry skid buffer so `in_ready` is registered, synchronous flush, hold from the hazard unit, and a saturating stall counter for performance monitoring. It sits between the fetch unit and the decoder, and is reusable for ID→EX and later stage boundaries.

---
 rtl/ifid_stage_reg_pkg.sv | 22 ++
 rtl/ifid_stage_reg_if.sv | 34 +++
 rtl/ifid_stage_reg_sat_counter.sv | 26 ++
 rtl/ifid_stage_reg.sv | 87 ++++++++
 tb/tb_ifid_stage_reg.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ifid_stage_reg_pkg.sv
// Shared pipeline-register definitions: state encoding, default NOP and the
// {instr, addr} entry layout used by IF->ID and later stage registers.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam logic [DATA_W_DEF-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  // Occupancy encoded as {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } stage_state_e;

  // Entry at default widths; the stage declares its own width-matched copy.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0] addr;
  } pipe_entry_t;

endpackage

// File: rtl/ifid_stage_reg_if.sv
// Bundle between fetch (upstream), the stage register and decode (downstream).
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both high; the sender keeps valid/data stable until it fires (flush aside),
// and ready never depends combinationally on valid of the same side.
interface ifid_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [ADDR_W-1:0] in_addr;
  logic              flush;
  logic              hold;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic [CNT_W-1:0]  stall_cnt;
  logic [1:0]        state;      // debug view of {skid_valid, main_valid}

  // Environment side: fetch, hazard unit and decoder.
  modport master (
    output in_valid, in_instr, in_addr, flush, hold, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, stall_cnt, state
  );

  // Stage-register side.
  modport slave (
    input  in_valid, in_instr, in_addr, flush, hold, out_ready,
    output in_ready, out_valid, out_instr, out_addr, stall_cnt, state
  );
endinterface

// File: rtl/ifid_stage_reg_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Advance only below the all-ones ceiling so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/ifid_stage_reg.sv
// IF->ID stage register: valid/ready handshake with a 2-entry skid buffer
// (main + skid) so in_ready comes straight from a flop, plus flush, hold and
// a saturating stall counter.
module ifid_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF),
  parameter int                CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 regReset_n,
  ifid_stage_reg_if.slave      bus
);
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  stage_state_e state_q, state_d;
  entry_t       main_q, skid_q, in_entry;
  logic         main_valid, in_ready, out_valid, in_fire, out_fire;
  logic         load_main_in, load_skid, load_main_skid, stall_inc;

  assign in_entry = '{instr: bus.in_instr, addr: bus.in_addr};

  // State register.
  always_ff @(posedge clk or negedge regReset_n) begin
    if (!regReset_n) state_q <= ST_EMPTY;
    else             state_q <= state_d;
  end

  // Next-state: occupancy moves by in_fire/out_fire; flush empties the stage.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (in_fire) state_d = ST_ONE;
      ST_ONE: begin
        if (in_fire && !out_fire)      state_d = ST_TWO;
        else if (!in_fire && out_fire) state_d = ST_EMPTY;
      end
      ST_TWO:   if (out_fire) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (bus.flush) state_d = ST_EMPTY;
  end

  // Outputs and datapath controls. in_ready depends only on state_q, so
  // there is no path from out_ready or hold into in_ready.
  always_comb begin
    main_valid     = (state_q == ST_ONE) || (state_q == ST_TWO);
    in_ready       = (state_q != ST_TWO);
    out_valid      = main_valid && !bus.hold;
    in_fire        = bus.in_valid && in_ready;
    out_fire       = out_valid && bus.out_ready;
    load_main_in   = !bus.flush && in_fire &&
                     ((state_q == ST_EMPTY) || ((state_q == ST_ONE) && out_fire));
    load_skid      = !bus.flush && in_fire && (state_q == ST_ONE) && !out_fire;
    load_main_skid = !bus.flush && (state_q == ST_TWO) && out_fire;
    stall_inc      = main_valid && (bus.hold || !bus.out_ready) && !bus.flush;
    bus.in_ready   = in_ready;
    bus.out_valid  = out_valid;
    bus.out_instr  = main_valid ? main_q.instr : NOP_INSTR;
    bus.out_addr   = main_valid ? main_q.addr : '0;
    bus.state      = state_q;
  end

  // Entry storage; payload flops only move on the controls above.
  always_ff @(posedge clk or negedge regReset_n) begin
    if (!regReset_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_entry;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (regReset_n),
    .inc_i (stall_inc),
    .cnt_o (bus.stall_cnt)
  );
endmodule

// File: tb/tb_ifid_stage_reg.sv
module tb_ifid_stage_reg;
  localparam int          DATA_W  = 32;
  localparam int          ADDR_W  = 32;
  localparam int          CNT_W   = 4;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  ifid_stage_reg_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  ifid_stage_reg #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .regReset_n (rst_n),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The stage is a FIFO of at most two {instr, addr} entries. The head is
  // what decode sees; the stage accepts while fewer than two are held.
  logic [DATA_W+ADDR_W-1:0] exp_q[$];
  int                       exp_cnt;
  logic                     m_ov, m_rdy, m_ofire, m_ifire;
  logic [DATA_W-1:0]        m_instr;
  logic [ADDR_W-1:0]        m_addr;

  always @(negedge clk) begin : cmp
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_out_instr", bus.out_instr, NOP);
      check("rst_out_addr",  bus.out_addr,  0);
      check("rst_stall_cnt", bus.stall_cnt, 0);
    end else begin
      m_rdy   = exp_q.size() < 2;
      m_ov    = (exp_q.size() > 0) && !bus.hold;
      m_instr = (exp_q.size() > 0) ? exp_q[0][DATA_W+ADDR_W-1:ADDR_W] : NOP;
      m_addr  = (exp_q.size() > 0) ? exp_q[0][ADDR_W-1:0] : '0;
      check("in_ready",  bus.in_ready,  m_rdy);
      check("out_valid", bus.out_valid, m_ov);
      check("out_instr", bus.out_instr, m_instr);
      check("out_addr",  bus.out_addr,  m_addr);
      check("stall_cnt", bus.stall_cnt, exp_cnt);
      check("state_legal", (bus.state == 2'b10), 0);
      // Advance the model across the coming rising edge.
      m_ofire = m_ov && bus.out_ready;
      m_ifire = bus.in_valid && m_rdy;
      if ((exp_q.size() > 0) && (bus.hold || !bus.out_ready) && !bus.flush &&
          (exp_cnt < CNT_MAX))
        exp_cnt++;
      if (bus.flush) exp_q.delete();
      else begin
        if (m_ofire) void'(exp_q.pop_front());
        if (m_ifire) exp_q.push_back({bus.in_instr, bus.in_addr});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] a,
                      input logic ordy, input logic hld, input logic fl);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_addr   = a;
    bus.out_ready = ordy;
    bus.hold      = hld;
    bus.flush     = fl;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.in_valid = 0; bus.out_ready = 0; bus.hold = 0; bus.flush = 0;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 0;
    bus.in_valid = 0; bus.in_instr = '0; bus.in_addr = '0;
    bus.out_ready = 0; bus.hold = 0; bus.flush = 0;
    @(negedge clk);
    #1 rst_n = 1;

    // Back-to-back stream, decoder always ready.
    do_reset();
    step(1, 32'h11, 32'h0, 1, 0, 0);
    check("s1_ready", bus.in_ready, 1);
    check("s1_empty", bus.out_valid, 0);
    step(1, 32'h22, 32'h4, 1, 0, 0);
    check("s1_v0", bus.out_valid, 1); check("s1_i0", bus.out_instr, 32'h11); check("s1_a0", bus.out_addr, 32'h0);
    step(1, 32'h33, 32'h8, 1, 0, 0);
    check("s1_i1", bus.out_instr, 32'h22); check("s1_a1", bus.out_addr, 32'h4); check("s1_rdy1", bus.in_ready, 1);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("s1_i2", bus.out_instr, 32'h33); check("s1_a2", bus.out_addr, 32'h8);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("s1_drained", bus.out_valid, 0); check("s1_nop", bus.out_instr, NOP); check("s1_cnt", bus.stall_cnt, 0);

    // Backpressure fills the skid entry.
    do_reset();
    step(1, 32'hA1, 32'h10, 0, 0, 0);
    step(1, 32'hA2, 32'h14, 0, 0, 0);
    check("s2_rdy_one", bus.in_ready, 1); check("s2_cnt0", bus.stall_cnt, 0);
    step(0, 32'h0, 32'h0, 0, 0, 0);
    check("s2_rdy_two", bus.in_ready, 0); check("s2_cnt1", bus.stall_cnt, 1);
    step(0, 32'h0, 32'h0, 0, 0, 0);
    check("s2_cnt2", bus.stall_cnt, 2);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("s2_first", bus.out_instr, 32'hA1); check("s2_cnt3", bus.stall_cnt, 3);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("s2_second", bus.out_instr, 32'hA2); check("s2_rdy_back", bus.in_ready, 1);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("s2_done", bus.out_valid, 0);

    // Hold for four cycles.
    do_reset();
    step(1, 32'hB1, 32'h20, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 32'h0, 32'h0, 1, 1, 0);
      check("s3_held_v", bus.out_valid, 0); check("s3_held_i", bus.out_instr, 32'hB1);
    end
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("s3_cnt4", bus.stall_cnt, 4); check("s3_rel", bus.out_valid, 1); check("s3_rel_i", bus.out_instr, 32'hB1);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("s3_once", bus.out_valid, 0);

    // Flush in TWO with a concurrent input.
    do_reset();
    step(1, 32'hC1, 32'h30, 0, 0, 0);
    step(1, 32'hC2, 32'h34, 0, 0, 0);
    step(1, 32'hC3, 32'h38, 0, 0, 1);
    check("s4_two", bus.in_ready, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("s4_v", bus.out_valid, 0); check("s4_nop", bus.out_instr, NOP); check("s4_rdy", bus.in_ready, 1);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("s4_no_c3", bus.out_valid, 0);

    // Counter saturation.
    do_reset();
    step(1, 32'hD1, 32'h40, 0, 0, 0);
    repeat (20) step(0, 32'h0, 32'h0, 0, 0, 0);
    check("s5_sat", bus.stall_cnt, 15);
    step(0, 32'h0, 32'h0, 0, 0, 0);
    check("s5_sat_hold", bus.stall_cnt, 15);

    // Asynchronous reset in TWO.
    do_reset();
    step(1, 32'hE1, 32'h50, 0, 0, 0);
    step(1, 32'hE2, 32'h54, 0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0, 0);
    check("s6_two", bus.in_ready, 0); check("s6_head", bus.out_instr, 32'hE1);
    #1 rst_n = 0;
    #1;
    check("s6_async_v", bus.out_valid, 0); check("s6_async_rdy", bus.in_ready, 1);
    check("s6_async_i", bus.out_instr, NOP); check("s6_async_a", bus.out_addr, 0);
    check("s6_async_cnt", bus.stall_cnt, 0);
    @(negedge clk);
    #1 rst_n = 1;
    step(1, 32'hF1, 32'h60, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("s6_restart_v", bus.out_valid, 1); check("s6_restart_i", bus.out_instr, 32'hF1);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("s6_restart_once", bus.out_valid, 0);

    // Randomised traffic against the model.
    do_reset();
    repeat (2000) begin
      step(($urandom_range(0, 3) != 0), $urandom, ($urandom & 32'hFFFF_FFFC),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 24) == 0));
    end
    repeat (4) step(0, 32'h0, 32'h0, 1, 0, 0);

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
